// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: FSM encoding and device-window decode constants.
package bridge_pkg;

  localparam int DEV_TAG_W = 12;
  localparam logic [DEV_TAG_W-1:0] BASE_TAG_DEF = 12'h7F0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_DONE  = S_DONE,
    ST_ERR   = S_ERR
  } state_t;

endpackage

// File: rtl/bridge_decode.sv
// Combinational window decoder: address tag PrAddr[15:4] to one-hot device select plus hit flag.
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int NUM_DEV = 2,
  parameter logic [DEV_TAG_W-1:0] BASE_TAG = BASE_TAG_DEF
) (
  input  logic [DEV_TAG_W-1:0] tag,
  output logic [NUM_DEV-1:0]   sel,
  output logic                 hit
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      sel[i] = (tag == DEV_TAG_W'(BASE_TAG + DEV_TAG_W'(i)));
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/sys_bridge.sv
// Bridge from the CPU data port to NUM_DEV 16-byte device windows with registered strobes and ready wait.
// Optional access timeout is compiled in with the SYS_BRIDGE_TIMEOUT_EN macro.
module sys_bridge
  import bridge_pkg::*;
#(
  parameter int NUM_DEV = 2,
  parameter logic [DEV_TAG_W-1:0] BASE_TAG = BASE_TAG_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            PrAddr,
  input  logic [31:0]            PrWD,
  input  logic [3:0]             PrBE,
  input  logic                   PrWE,
  input  logic                   PrRE,
  output logic [31:0]            PrRD,
  output logic                   PrStall,
  output logic                   PrErr,
  output logic [31:0]            DEV_Addr,
  output logic [31:0]            DEV_WD,
  output logic [3:0]             DEV_BE,
  output logic [NUM_DEV-1:0]     DEV_WE,
  output logic [NUM_DEV-1:0]     DEV_RE,
  input  logic [32*NUM_DEV-1:0]  DEV_RD,
  input  logic [NUM_DEV-1:0]     DEV_Ready,
  output logic [2:0]             dbg_state
);

  state_t state, state_nx;
  logic [NUM_DEV-1:0] sel_dec, sel_q;
  logic hit, wr_q, req, rdy, expired;
  logic [31:0] rd_sel;

  bridge_decode #(.NUM_DEV(NUM_DEV), .BASE_TAG(BASE_TAG)) u_decode (
    .tag (PrAddr[15:4]),
    .sel (sel_dec),
    .hit (hit)
  );

  assign req       = PrWE | PrRE;
  assign rdy       = |(DEV_Ready & sel_q);
  assign dbg_state = state;
  assign PrStall   = ((state == ST_IDLE) && req) || (state == ST_ISSUE) || (state == ST_WAIT);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (sel_q[i]) rd_sel = DEV_RD[32*i +: 32];
    end
  end

`ifdef SYS_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // cnt holds the unready samples already taken; this sample is the TIMEOUT-th when it equals TIMEOUT-1
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (((state == ST_ISSUE) || (state == ST_WAIT)) && !rdy) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  // Only an illegal TIMEOUT (<1) could abandon an access; otherwise WAIT holds until ready.
  assign expired = (TIMEOUT < 1);
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:          if (req) state_nx = hit ? ST_ISSUE : ST_ERR;
      ST_ISSUE, ST_WAIT: begin
        if (rdy)          state_nx = ST_DONE;
        else if (expired) state_nx = ST_ERR;
        else              state_nx = ST_WAIT;
      end
      ST_DONE, ST_ERR:  state_nx = ST_IDLE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DEV_Addr <= '0;
      DEV_WD   <= '0;
      DEV_BE   <= '0;
      DEV_WE   <= '0;
      DEV_RE   <= '0;
      PrErr    <= 1'b0;
      PrRD     <= '0;
      sel_q    <= '0;
      wr_q     <= 1'b0;
    end else begin
      DEV_WE <= '0;
      DEV_RE <= '0;
      PrErr  <= 1'b0;
      if ((state == ST_IDLE) && req) begin
        DEV_Addr <= PrAddr;
        DEV_WD   <= PrWD;
        DEV_BE   <= PrBE;
        sel_q    <= sel_dec;
        wr_q     <= PrWE;
        // Strobe is registered so it is high exactly during ISSUE; write wins over read.
        if (hit) begin
          if (PrWE) DEV_WE <= sel_dec;
          else      DEV_RE <= sel_dec;
        end
      end
      if (((state == ST_ISSUE) || (state == ST_WAIT)) && rdy && !wr_q) PrRD <= rd_sel;
      if (state_nx == ST_ERR) begin
        PrErr <= 1'b1;
        PrRD  <= '0;
      end
    end
  end

endmodule

// File: doc/sys_bridge.md
# sys_bridge

Parametrised system bridge between the CPU's data-memory port and NUM_DEV memory-mapped peripherals, such as the timer and the I/O devices. It decodes 16-byte device windows, issues registered one-cycle strobes and waits for each device's ready handshake. It stalls the CPU while an access is outstanding, registers read data and flags unmapped or timed-out accesses. It sits beside the data memory in the MEM stage.

## Interface
Parameters:
- NUM_DEV, 2: number of devices, 1..8.
- BASE_TAG, 12'h7F0: device i is selected when PrAddr[15:4] == BASE_TAG + i.
- TIMEOUT, 15: number of ready-sampling cycles before an access is abandoned; must be at least 1.

Ports:
- clk  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- PrAddr  in  32: CPU byte address.
- PrWD  in  32: CPU write data.
- PrBE  in  4: CPU byte enables.
- PrWE  in  1: CPU write request.
- PrRE  in  1: CPU read request.
- PrRD  out  32: registered read data.
- PrStall  out  1: freeze the pipeline.
- PrErr  out  1: one-cycle pulse flagging a bus error.
- DEV_Addr  out  32: latched address.
- DEV_WD  out  32: latched write data.
- DEV_BE  out  4: latched byte enables.
- DEV_WE  out  NUM_DEV: one-hot write strobe.
- DEV_RE  out  NUM_DEV: one-hot read strobe.
- DEV_RD  in  32*NUM_DEV: read data; device i drives bits [32i+31:32i].
- DEV_Ready  in  NUM_DEV: per-device completion.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- Request definitions:
  - req = PrWE | PrRE.
  - If PrWE and PrRE are both high, the access is a write.
- IDLE with req:
  - Latch PrAddr, PrWD, PrBE, the direction and the decoded one-hot sel.
  - On a hit, go to ISSUE.
  - On a miss (tag outside BASE_TAG..BASE_TAG+NUM_DEV-1), go to ERR. No strobe is driven.
- ISSUE (exactly one cycle):
  - DEV_WE[sel] or DEV_RE[sel] is high.
  - The timeout counter is cleared.
  - DEV_Ready[sel] is sampled. If high, go to DONE; otherwise go to WAIT.
- WAIT:
  - Strobes are low.
  - If DEV_Ready[sel] is high, go to DONE.
  - Otherwise the counter increments.
  - When TIMEOUT sampled cycles, ISSUE included, pass without ready, go to ERR.
- Ready capture: on the cycle ready is sampled high for a read, DEV_RD slice sel is captured into PrRD. Writes leave PrRD unchanged.
- DONE:
  - Lasts one cycle, then goes to IDLE.
  - PrStall is low, so the CPU advances. The still-held request is not reissued.
- ERR:
  - Lasts one cycle, then goes to IDLE.
  - PrErr=1, PrStall=0, PrRD=0.
- Ignored inputs:
  - DEV_Ready bits other than sel.
  - Any DEV_Ready seen in IDLE, DONE or ERR.
- PrStall (combinational) = (IDLE & req) | ISSUE | WAIT.
- The CPU holds PrAddr, PrWD, PrBE, PrWE and PrRE stable while PrStall is high. Changes after latching are ignored.

## Timing
- Reset values:
  - State IDLE.
  - DEV_WE, DEV_RE, PrErr and the counter are 0.
  - PrRD, DEV_Addr, DEV_WD and DEV_BE are 0.
- Reset takes effect immediately, including mid-access: strobes drop without waiting for a clock edge.
- Minimum access, ready high in ISSUE:
  - T0: IDLE, stall.
  - T1: ISSUE, strobe, stall.
  - T2: DONE, PrRD valid, no stall.
  - Three cycles total, two stalled.
- Each WAIT cycle adds one cycle.
- Unmapped access:
  - T0: stall.
  - T1: ERR.
- Timeout: ERR is entered on the cycle after the TIMEOUT-th unready sample.
- A new request may be accepted in the IDLE cycle immediately following DONE or ERR.

## Configuration
- Macro: SYS_BRIDGE_TIMEOUT_EN.
- When defined: the timeout counter, of width $clog2(TIMEOUT+1), and the WAIT-to-ERR transition exist.
- When undefined: there is no counter. WAIT holds until DEV_Ready[sel], and PrErr is raised only for unmapped accesses.

## Structure
- Shared package bridge_pkg holds:
  - The state encoding (3-bit localparams for IDLE, ISSUE, WAIT, DONE, ERR).
  - DEV_TAG_W = 12.
  - The default BASE_TAG.
- One sub-module, bridge_decode, is combinational and parametrised by NUM_DEV and BASE_TAG:
  - Input: PrAddr[15:4].
  - Outputs: one-hot sel[NUM_DEV-1:0] and hit.
- The FSM, counter, latches and read-data mux live in sys_bridge.

## Test plan
- Fast read (NUM_DEV=2): read from 0x7F10 with device 1 ready in ISSUE and DEV_RD slice 1 = 0xDEADBEEF.
  - DEV_RE=2'b10 for one cycle; PrStall high for 2 cycles; PrRD=0xDEADBEEF at T2.
- Slow write: write 0x12345678 to 0x7F04 with PrBE=4'b0011 and device 0 ready 3 cycles after ISSUE.
  - DEV_WE=2'b01 for exactly one cycle; DEV_BE=4'b0011; stall for 5 cycles; PrRD unchanged.
- Unmapped: read from 0x7F20.
  - No strobe; PrErr=1 at T1; PrRD=0; stall for 1 cycle.
- Timeout (macro defined, TIMEOUT=4): read device 0 with ready never asserted.
  - ERR on the cycle after the 4th unready sample; PrErr pulse.
  - Without the macro: stall persists for 50 cycles until ready is driven.
- Conflicts: PrWE and PrRE high together; device 0 ready held high in IDLE; device 1 ready pulsed during a device-0 access.
  - Treated as a write; stray ready bits are ignored.
  - Back-to-back requests: the second is latched in the IDLE cycle after DONE.
- Reset mid-WAIT: reset low asynchronously.
  - State IDLE and strobes 0 before the next edge.
  - After reset is released, the next access completes normally.
